magnitude_comparator: RTL and testbench
=======================================

MAGNITUDE_COMPARATOR -- requirements
Module: magnitude_comparator

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Port clk input 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst input 1: reset, synchronous and active-high.
REQ-004 Port in_valid input 1: a, b and signed_mode are sampled when high.
REQ-005 Port signed_mode input 1: 0 = unsigned compare, 1 = two's-complement compare.
REQ-006 Port a input WIDTH: operand A.
REQ-007 Port b input WIDTH: operand B.
REQ-008 Port a_gt_b output 1: registered, A greater than B.
REQ-009 Port a_eq_b output 1: registered, A equal to B.
REQ-010 Port a_lt_b output 1: registered, A less than B.
REQ-011 Port max_out output WIDTH: registered, the larger operand (A when equal).
REQ-012 Port min_out output WIDTH: registered, the smaller operand (B when equal).
REQ-013 Port out_valid output 1: registered, high for exactly one cycle per accepted input.

Function
REQ-014 Latency SHALL be one cycle: inputs sampled at edge N with in_valid=1 appear on outputs after edge N, with out_valid=1.
REQ-015 Exactly one of a_gt_b, a_eq_b, a_lt_b SHALL be 1 whenever out_valid=1 (one-hot).
REQ-016 When signed_mode=0, operands SHALL be compared as unsigned: 0..2^WIDTH-1.
REQ-017 When signed_mode=1, operands SHALL be compared as two's complement: MSB set means negative.
REQ-018 a_eq_b SHALL depend only on bit equality, independent of signed_mode.
REQ-019 When in_valid=0 at an edge, out_valid SHALL drop to 0 and all other outputs SHALL hold their last values.
REQ-020 Back-to-back in_valid SHALL be accepted every cycle with no stall, one result per cycle.
REQ-021 No arithmetic subtraction SHALL be used; the result is formed by cascading 4-bit slice comparators from MSB slice to LSB slice.
- Upper slice decides unless equal; equal slices pass the lower slice's decision upward.
- The LSB slice's cascade inputs are tied to "equal".
REQ-022 Signed handling SHALL be done by inverting the operand MSBs before the cascade when signed_mode=1.
REQ-023 Boundary values SHALL compare correctly.
- Unsigned: 0 vs 2^WIDTH-1.
- Signed: most-negative vs most-positive.
- All-ones vs all-ones.

Reset
REQ-024 While rst=1 at a clock edge, registered outputs SHALL take these values:
- a_gt_b=0, a_eq_b=1, a_lt_b=0;
- max_out=0, min_out=0, out_valid=0.
REQ-025 rst SHALL take priority over in_valid; an input presented in the same cycle as rst SHALL be discarded.
REQ-026 The first valid result SHALL appear one cycle after the first in_valid=1 following reset release.

Structure
REQ-027 A shared package SHALL hold:
- the slice width constant (4);
- the cmp_result_t enum {GT, EQ, LT};
- the default WIDTH.
REQ-028 One sub-module, comparator_slice4, SHALL implement a 4-bit compare with cascade inputs gt_in, eq_in, lt_in and outputs gt_out, eq_out, lt_out; the top instantiates WIDTH/4 of them with a generate loop.
REQ-029 The top SHALL contain only the MSB-inversion logic, the slice chain, the max/min mux and the output register stage.

Verification
REQ-030 Unsigned, WIDTH=4: (5,3) -> gt=1, max=5, min=3; (7,7) -> eq=1, max=7, min=7; (2,10) -> lt=1, max=10, min=2; (0,0) -> eq=1; (15,8) -> gt=1. Each result appears one cycle after in_valid, with out_valid pulsed.
REQ-031 Signed, WIDTH=4: (4'b1111, 4'b0001), i.e. -1 vs 1 -> lt=1. The same operands with signed_mode=0 -> gt=1.
REQ-032 Signed extremes: (4'b1000, 4'b0111) -> lt=1. Unsigned extremes: (0, 15) -> lt=1.
REQ-033 Streaming: eight consecutive in_valid cycles of random operands -> eight consecutive out_valid cycles, each result matching a reference model.
REQ-034 Reset: assert rst in the same cycle as an input -> next cycle out_valid=0 and eq=1. Then in_valid=0 for three cycles -> outputs hold and out_valid stays 0.
REQ-035 WIDTH=8: (200, 199) unsigned -> gt=1. (8'h80, 8'h7F) signed -> lt=1.

Source files
------------

// File: rtl/magnitude_comparator_pkg.sv
// ============================================================================
// Module  : magnitude_comparator_pkg
// Brief   : Shared constants, result enum and helpers for the magnitude comparator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package magnitude_comparator_pkg;

    localparam int SLICE_W       = 4;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        GT = 2'd0,
        EQ = 2'd1,
        LT = 2'd2
    } cmp_result_t;

    function automatic int num_slices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/magnitude_comparator_if.sv
// ============================================================================
// Module  : magnitude_comparator_if
// Brief   : Operand/result bundle between a requester and the comparator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface magnitude_comparator_if
    import magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic [WIDTH-1:0] max_out;
    logic [WIDTH-1:0] min_out;
    logic             out_valid;

    modport master (
        output in_valid, signed_mode, a, b,
        input  a_gt_b, a_eq_b, a_lt_b, max_out, min_out, out_valid
    );

    modport slave (
        input  in_valid, signed_mode, a, b,
        output a_gt_b, a_eq_b, a_lt_b, max_out, min_out, out_valid
    );

endinterface

`default_nettype wire

// File: rtl/magnitude_comparator_slice4.sv
// ============================================================================
// Module  : comparator_slice4
// Brief   : 4-bit cascadable magnitude compare; defers to cascade inputs on a tie.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_slice4
    import magnitude_comparator_pkg::*;
(
    input  wire logic [SLICE_W-1:0] a_i,
    input  wire logic [SLICE_W-1:0] b_i,
    input  wire logic               gt_in,
    input  wire logic               eq_in,
    input  wire logic               lt_in,
    output logic                    gt_out,
    output logic                    eq_out,
    output logic                    lt_out
);

    logic w_gt;
    logic w_lt;
    logic w_found;

    // The most significant differing bit decides; no subtraction involved.
    always_comb begin
        w_gt    = 1'b0;
        w_lt    = 1'b0;
        w_found = 1'b0;
        for (int i = SLICE_W - 1; i >= 0; i--) begin
            if (!w_found && (a_i[i] ^ b_i[i])) begin
                w_gt    = a_i[i];
                w_lt    = b_i[i];
                w_found = 1'b1;
            end
        end
    end

    assign gt_out = w_gt | (~w_found & gt_in);
    assign eq_out = ~w_found & eq_in;
    assign lt_out = w_lt | (~w_found & lt_in);

endmodule

`default_nettype wire

// File: rtl/magnitude_comparator.sv
// ============================================================================
// Module  : magnitude_comparator
// Brief   : Registered signed/unsigned compare with max/min select, 1-cycle latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module magnitude_comparator
    import magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              rst,
    magnitude_comparator_if.slave  bus
);

    localparam int NSLICE = num_slices(WIDTH);

    logic [WIDTH-1:0] w_msb_flip;
    logic [WIDTH-1:0] w_a_cmp;
    logic [WIDTH-1:0] w_b_cmp;
    logic [NSLICE:0]  w_gt_c;
    logic [NSLICE:0]  w_eq_c;
    logic [NSLICE:0]  w_lt_c;
    cmp_result_t      w_res;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign w_msb_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};
    assign w_a_cmp    = bus.a ^ w_msb_flip;
    assign w_b_cmp    = bus.b ^ w_msb_flip;

    assign w_gt_c[0] = 1'b0;
    assign w_eq_c[0] = 1'b1;
    assign w_lt_c[0] = 1'b0;

    generate
        for (genvar k = 0; k < NSLICE; k++) begin : g_slice
            comparator_slice4 u_slice (
                .a_i    (w_a_cmp[k*SLICE_W +: SLICE_W]),
                .b_i    (w_b_cmp[k*SLICE_W +: SLICE_W]),
                .gt_in  (w_gt_c[k]),
                .eq_in  (w_eq_c[k]),
                .lt_in  (w_lt_c[k]),
                .gt_out (w_gt_c[k+1]),
                .eq_out (w_eq_c[k+1]),
                .lt_out (w_lt_c[k+1])
            );
        end
    endgenerate

    always_comb begin
        w_res = EQ;
        unique case ({w_gt_c[NSLICE], w_eq_c[NSLICE], w_lt_c[NSLICE]})
            3'b100:  w_res = GT;
            3'b001:  w_res = LT;
            default: w_res = EQ;
        endcase
    end

    logic             gt_d, eq_d, lt_d;
    logic [WIDTH-1:0] max_d, min_d;
    logic             gt_q, eq_q, lt_q, valid_q;
    logic [WIDTH-1:0] max_q, min_q;

    // On a tie A is reported as max and B as min.
    always_comb begin
        gt_d  = (w_res == GT);
        eq_d  = (w_res == EQ);
        lt_d  = (w_res == LT);
        max_d = (w_res == LT) ? bus.b : bus.a;
        min_d = (w_res == LT) ? bus.a : bus.b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            max_q   <= '0;
            min_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            max_q   <= max_d;
            min_q   <= min_d;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.a_gt_b    = gt_q;
    assign bus.a_eq_b    = eq_q;
    assign bus.a_lt_b    = lt_q;
    assign bus.max_out   = max_q;
    assign bus.min_out   = min_q;
    assign bus.out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_magnitude_comparator.sv
// ============================================================================
// Module  : tb_magnitude_comparator
// Brief   : Directed + random bench for 4- and 8-bit comparators against an integer model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magnitude_comparator;
    import magnitude_comparator_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    magnitude_comparator_if #(.WIDTH(4)) if4 ();
    magnitude_comparator_if #(.WIDTH(8)) if8 ();

    magnitude_comparator #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    magnitude_comparator #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    typedef struct {
        logic       gt, eq, lt, v;
        logic [7:0] mx, mn;
    } exp_t;

    exp_t e4, e8;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Operands become plain integers; the ordering of those integers is the answer.
    function automatic exp_t model(input exp_t prev, input int w, input logic r, input logic v,
                                   input logic sm, input logic [7:0] a, input logic [7:0] b);
        exp_t n;
        int   va, vb;
        n  = prev;
        va = int'(a);
        vb = int'(b);
        if (sm && a[w-1]) va = va - (1 << w);
        if (sm && b[w-1]) vb = vb - (1 << w);
        if (r) begin
            n.gt = 1'b0; n.eq = 1'b1; n.lt = 1'b0;
            n.mx = '0;   n.mn = '0;   n.v  = 1'b0;
        end else if (v) begin
            n.gt = (va > vb);
            n.eq = (va == vb);
            n.lt = (va < vb);
            n.mx = (va >= vb) ? a : b;
            n.mn = (va >= vb) ? b : a;
            n.v  = 1'b1;
        end else begin
            n.v = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set4(input logic v, input logic sm, input logic [3:0] a, input logic [3:0] b);
        if4.in_valid = v; if4.signed_mode = sm; if4.a = a; if4.b = b;
    endtask

    task automatic set8(input logic v, input logic sm, input logic [7:0] a, input logic [7:0] b);
        if8.in_valid = v; if8.signed_mode = sm; if8.a = a; if8.b = b;
    endtask

    task automatic tick();
        exp_t n4, n8;
        n4 = model(e4, 4, rst, if4.in_valid, if4.signed_mode, {4'b0, if4.a}, {4'b0, if4.b});
        n8 = model(e8, 8, rst, if8.in_valid, if8.signed_mode, if8.a, if8.b);
        @(posedge clk);
        e4 = n4;
        e8 = n8;
        #1;
    endtask

    task automatic chk4(input string tag);
        chk({tag, "_v4"},   if4.out_valid, e4.v);
        chk({tag, "_gt4"},  if4.a_gt_b,    e4.gt);
        chk({tag, "_eq4"},  if4.a_eq_b,    e4.eq);
        chk({tag, "_lt4"},  if4.a_lt_b,    e4.lt);
        chk({tag, "_max4"}, if4.max_out,   e4.mx[3:0]);
        chk({tag, "_min4"}, if4.min_out,   e4.mn[3:0]);
        if (if4.out_valid)
            chk({tag, "_oh4"}, $onehot({if4.a_gt_b, if4.a_eq_b, if4.a_lt_b}), 1);
    endtask

    task automatic chk8(input string tag);
        chk({tag, "_v8"},   if8.out_valid, e8.v);
        chk({tag, "_gt8"},  if8.a_gt_b,    e8.gt);
        chk({tag, "_eq8"},  if8.a_eq_b,    e8.eq);
        chk({tag, "_lt8"},  if8.a_lt_b,    e8.lt);
        chk({tag, "_max8"}, if8.max_out,   e8.mx);
        chk({tag, "_min8"}, if8.min_out,   e8.mn);
        if (if8.out_valid)
            chk({tag, "_oh8"}, $onehot({if8.a_gt_b, if8.a_eq_b, if8.a_lt_b}), 1);
    endtask

    // Directed 4-bit vectors with hand-derived results.
    logic [3:0] ta  [10] = '{4'd5, 4'd7, 4'd2,  4'd0, 4'd15, 4'hF, 4'hF, 4'h8, 4'd0,  4'hF};
    logic [3:0] tb  [10] = '{4'd3, 4'd7, 4'd10, 4'd0, 4'd8,  4'h1, 4'h1, 4'h7, 4'd15, 4'hF};
    logic       tsm [10] = '{1'b0, 1'b0, 1'b0,  1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0,  1'b1};
    logic [2:0] tres[10] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100,
                             3'b001, 3'b100, 3'b001, 3'b001, 3'b010};
    logic [3:0] tmax[10] = '{4'd5, 4'd7, 4'd10, 4'd0, 4'd15, 4'h1, 4'hF, 4'h7, 4'd15, 4'hF};
    logic [3:0] tmin[10] = '{4'd3, 4'd7, 4'd2,  4'd0, 4'd8,  4'hF, 4'h1, 4'h8, 4'd0,  4'hF};

    logic [7:0] ua  [4] = '{8'd200, 8'h80, 8'h00, 8'h80};
    logic [7:0] ub  [4] = '{8'd199, 8'h7F, 8'hFF, 8'h7F};
    logic       usm [4] = '{1'b0,   1'b1,  1'b0,  1'b0};
    logic [2:0] ures[4] = '{3'b100, 3'b001, 3'b001, 3'b100};

    initial begin
        e4  = '{gt: 1'b0, eq: 1'b1, lt: 1'b0, v: 1'b0, mx: 8'h0, mn: 8'h0};
        e8  = e4;
        rst = 1'b1;
        set4(1'b0, 1'b0, 4'h0, 4'h0);
        set8(1'b0, 1'b0, 8'h0, 8'h0);
        tick();
        tick();
        chk4("reset");
        chk8("reset");
        chk("reset_eq_const", if4.a_eq_b, 1);

        rst = 1'b0;
        tick();
        chk4("idle_after_reset");

        // Back-to-back directed 4-bit vectors.
        for (int i = 0; i < 10; i++) begin
            set4(1'b1, tsm[i], ta[i], tb[i]);
            tick();
            chk4($sformatf("dir4_%0d", i));
            chk($sformatf("dir4_%0d_res", i), {if4.a_gt_b, if4.a_eq_b, if4.a_lt_b}, tres[i]);
            chk($sformatf("dir4_%0d_max", i), if4.max_out, tmax[i]);
            chk($sformatf("dir4_%0d_min", i), if4.min_out, tmin[i]);
            chk($sformatf("dir4_%0d_ov", i), if4.out_valid, 1);
        end
        set4(1'b0, 1'b0, 4'h3, 4'h9);
        tick();
        chk4("drop_valid");
        chk("drop_valid_ov", if4.out_valid, 0);

        for (int i = 0; i < 4; i++) begin
            set8(1'b1, usm[i], ua[i], ub[i]);
            tick();
            chk8($sformatf("dir8_%0d", i));
            chk($sformatf("dir8_%0d_res", i), {if8.a_gt_b, if8.a_eq_b, if8.a_lt_b}, ures[i]);
        end
        set8(1'b0, 1'b0, 8'h0, 8'h0);
        tick();
        chk8("drop_valid8");

        // Hold with non-reset values, then reset colliding with a valid input.
        set4(1'b1, 1'b0, 4'd9, 4'd3);
        tick();
        set4(1'b0, 1'b0, 4'd1, 4'd14);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4($sformatf("hold_%0d", i));
            chk($sformatf("hold_%0d_max", i), if4.max_out, 4'd9);
        end
        set4(1'b1, 1'b0, 4'd4, 4'd12);
        set8(1'b1, 1'b0, 8'd40, 8'd12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set4(1'b0, 1'b0, 4'd4, 4'd12);
        set8(1'b0, 1'b0, 8'd40, 8'd12);
        chk4("rst_discard");
        chk8("rst_discard");
        chk("rst_discard_ov", if4.out_valid, 0);
        chk("rst_discard_eq", if4.a_eq_b, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4($sformatf("post_rst_idle_%0d", i));
        end

        // Eight-cycle streaming burst on both widths.
        for (int i = 0; i < 8; i++) begin
            set4(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            set8(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            tick();
            chk4($sformatf("stream_%0d", i));
            chk8($sformatf("stream_%0d", i));
        end

        // Random traffic with gaps and occasional reset.
        for (int i = 0; i < 200; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            set4(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            set8(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            tick();
            chk4($sformatf("rand_%0d", i));
            chk8($sformatf("rand_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
